// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the ADT7420 I2C reader
// Contents:
//   i2c_state_t          transaction sequencer states
//   ADT7420_ADDR         default 7-bit sensor address
//   I2C_CLK_DIV_100KHZ   clk_100MHz cycles per quarter SCL period
//   PH_0..PH_3           phase indices within one SCL bit
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_RD_MSB,
    ST_M_ACK,
    ST_RD_LSB,
    ST_M_NACK,
    ST_STOP
  } i2c_state_t;

  localparam logic [6:0] ADT7420_ADDR       = 7'h4B;
  localparam int         I2C_CLK_DIV_100KHZ = 250;

  localparam logic [1:0] PH_0 = 2'd0;
  localparam logic [1:0] PH_1 = 2'd1;
  localparam logic [1:0] PH_2 = 2'd2;
  localparam logic [1:0] PH_3 = 2'd3;

endpackage

// File: rtl/i2c_phase_tick.sv
// rtl/i2c_phase_tick.sv - quarter-SCL-period divider and phase index
// Ports:
//   clk         system clock
//   reset       synchronous active-high reset
//   en          divider runs only while high; low clears divider and phase
//   phase_clr   on a tick, force the next phase index to PH_0 instead of +1
//   phase_tick  one-cycle pulse on the last cycle of each phase
//   phase       current phase index, wraps 3 -> 0
module i2c_phase_tick
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = I2C_CLK_DIV_100KHZ
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       phase_clr,
  output logic       phase_tick,
  output logic [1:0] phase
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] div_cnt;

  assign phase_tick = en && (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      div_cnt <= '0;
      phase   <= PH_0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      phase   <= phase_clr ? PH_0 : phase + 2'd1;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/i2c_temp_reader.sv
// rtl/i2c_temp_reader.sv - I2C master that reads one 16-bit word from the ADT7420
// Ports:
//   clk_100MHz  system clock
//   reset       synchronous active-high reset (releases bus, no STOP)
//   start       single-cycle request, accepted only while idle
//   sda_i       synchronised SDA pad level
//   sda_oe      1 = pull SDA low
//   scl_oe      1 = pull SCL low
//   busy        transaction in progress
//   temp_data   last successfully read word {MSB, LSB}
//   data_valid  one-cycle pulse when temp_data updates
//   ack_error   one-cycle pulse when the address byte was NACKed
module i2c_temp_reader
  import i2c_pkg::*;
#(
  parameter int         CLK_DIV    = I2C_CLK_DIV_100KHZ,
  parameter logic [6:0] SLAVE_ADDR = ADT7420_ADDR
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic        start,
  input  logic        sda_i,
  output logic        sda_oe,
  output logic        scl_oe,
  output logic        busy,
  output logic [15:0] temp_data,
  output logic        data_valid,
  output logic        ack_error
);

  localparam logic [7:0] ADDR_BYTE = {SLAVE_ADDR, 1'b1};

  i2c_state_t state, state_n;
  logic       phase_tick;
  logic [1:0] phase;
  logic       phase_clr;
  logic [2:0] bit_cnt;
  logic [7:0] rx_shift;
  logic [7:0] msb_byte;
  logic       addr_nack;
  logic       sample;
  logic       bit_end;
  logic       byte_end;
  logic       stop_end;

  assign busy      = (state != ST_IDLE);
  // START is only two phases long, so restart the phase count for the first bit
  assign phase_clr = (state == ST_START) && (phase == PH_1);
  assign sample    = phase_tick && (phase == PH_1);
  assign bit_end   = phase_tick && (phase == PH_3);
  assign byte_end  = bit_end && (bit_cnt == 3'd7);
  assign stop_end  = (state == ST_STOP) && phase_tick && (phase == PH_2);

  i2c_phase_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk        (clk_100MHz),
    .reset      (reset),
    .en         (busy),
    .phase_clr  (phase_clr),
    .phase_tick (phase_tick),
    .phase      (phase)
  );

  always_ff @(posedge clk_100MHz) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    sda_oe  = 1'b0;
    scl_oe  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_n = ST_START;
      end
      ST_START: begin
        sda_oe = (phase == PH_1);
        if (phase_tick && phase == PH_1) state_n = ST_ADDR;
      end
      ST_ADDR: begin
        sda_oe = !ADDR_BYTE[3'd7 - bit_cnt];
        scl_oe = (phase == PH_0) || (phase == PH_3);
        if (byte_end) state_n = ST_ADDR_ACK;
      end
      ST_ADDR_ACK: begin
        scl_oe = (phase == PH_0) || (phase == PH_3);
        if (bit_end) state_n = addr_nack ? ST_STOP : ST_RD_MSB;
      end
      ST_RD_MSB: begin
        scl_oe = (phase == PH_0) || (phase == PH_3);
        if (byte_end) state_n = ST_M_ACK;
      end
      ST_M_ACK: begin
        sda_oe = 1'b1;
        scl_oe = (phase == PH_0) || (phase == PH_3);
        if (bit_end) state_n = ST_RD_LSB;
      end
      ST_RD_LSB: begin
        scl_oe = (phase == PH_0) || (phase == PH_3);
        if (byte_end) state_n = ST_M_NACK;
      end
      ST_M_NACK: begin
        scl_oe = (phase == PH_0) || (phase == PH_3);
        if (bit_end) state_n = ST_STOP;
      end
      ST_STOP: begin
        // SCL low/SDA low, then SCL high/SDA low, then SDA rises: the STOP edge
        sda_oe = (phase != PH_2);
        scl_oe = (phase == PH_0);
        if (stop_end) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      bit_cnt    <= '0;
      rx_shift   <= '0;
      msb_byte   <= '0;
      addr_nack  <= 1'b0;
      temp_data  <= '0;
      data_valid <= 1'b0;
      ack_error  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      ack_error  <= 1'b0;
      if (bit_end && (state == ST_ADDR || state == ST_RD_MSB || state == ST_RD_LSB))
        bit_cnt <= bit_cnt + 3'd1;
      if (sample && (state == ST_RD_MSB || state == ST_RD_LSB))
        rx_shift <= {rx_shift[6:0], sda_i};
      // last MSB bit was shifted in at P1, so rx_shift is complete by P3
      if (byte_end && state == ST_RD_MSB)
        msb_byte <= rx_shift;
      if (state == ST_IDLE)
        addr_nack <= 1'b0;
      else if (sample && state == ST_ADDR_ACK)
        addr_nack <= sda_i;
      if (stop_end) begin
        if (addr_nack) begin
          ack_error <= 1'b1;
        end else begin
          data_valid <= 1'b1;
          temp_data  <= {msb_byte, rx_shift};
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_temp_reader.sv
// tb/tb_i2c_temp_reader.sv - self-checking bench for i2c_temp_reader with ADT7420 slave model
module tb_i2c_temp_reader;

  localparam int CD = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        sda_oe, scl_oe, busy, data_valid, ack_error;
  logic [15:0] temp_data;
  logic        slave_pull = 1'b0;
  wire         sda_line = ~(sda_oe | slave_pull);
  wire         scl_line = ~scl_oe;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    bit          is_err;
    logic [15:0] data;
    int          due;
  } exp_t;
  exp_t exp_q[$];

  i2c_temp_reader #(.CLK_DIV(CD)) dut (
    .clk_100MHz (clk),
    .reset      (reset),
    .start      (start),
    .sda_i      (sda_line),
    .sda_oe     (sda_oe),
    .scl_oe     (scl_oe),
    .busy       (busy),
    .temp_data  (temp_data),
    .data_valid (data_valid),
    .ack_error  (ack_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_valid = 0;
  int n_err = 0;
  always @(negedge clk) begin
    if (data_valid) n_valid++;
    if (ack_error) n_err++;
  end

  // Slave model and bus protocol checker
  bit         ack_en = 1'b1;
  logic [7:0] byte0 = 8'h00;
  logic [7:0] byte1 = 8'h00;
  logic [7:0] addr_rx = 8'h00;
  logic       m_ack_bit = 1'b1;
  logic       m_nack_bit = 1'b0;
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  bit         in_xfer = 1'b0;
  int         nbit = 0;
  int         last_edge = 0;
  int         last_rise = 0;
  int         period_meas = 0;
  int         proto_err = 0;
  int         stops_seen = 0;

  always @(negedge clk) begin
    logic s_scl, s_sda;
    s_scl = scl_line;
    s_sda = sda_line;
    if (reset) begin
      in_xfer    = 1'b0;
      nbit       = 0;
      slave_pull = 1'b0;
    end else if (s_scl && prev_scl && s_sda != prev_sda) begin
      if (!s_sda) begin
        if (in_xfer) proto_err++;
        in_xfer = 1'b1;
        nbit = 0;
        slave_pull = 1'b0;
      end else begin
        if (!in_xfer || !(nbit == 28 || nbit == 10)) proto_err++;
        stops_seen++;
        in_xfer = 1'b0;
        slave_pull = 1'b0;
      end
    end else if (in_xfer && s_scl && !prev_scl) begin
      if (nbit > 0 && (cyc - last_edge) != 2 * CD) proto_err++;
      if (nbit < 8) addr_rx = {addr_rx[6:0], s_sda};
      if (nbit == 17) m_ack_bit = s_sda;
      if (nbit == 26) m_nack_bit = s_sda;
      if (nbit == 1) period_meas = cyc - last_rise;
      last_rise = cyc;
      last_edge = cyc;
      nbit++;
    end else if (in_xfer && !s_scl && prev_scl) begin
      if (nbit > 0 && (cyc - last_edge) != 2 * CD) proto_err++;
      last_edge = cyc;
      slave_pull = 1'b0;
      if (ack_en) begin
        if (nbit == 8) slave_pull = 1'b1;
        else if (nbit >= 9 && nbit <= 16) slave_pull = !byte0[3'(16 - nbit)];
        else if (nbit >= 18 && nbit <= 25) slave_pull = !byte1[3'(25 - nbit)];
      end
    end
    prev_scl = s_scl;
    prev_sda = s_sda;
  end

  task automatic do_start(input bit is_err, input logic [15:0] d, input int phases);
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1;
    e.is_err = is_err;
    e.data   = d;
    e.due    = cyc + 1 + phases * CD;
    exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_after_start: got %b want 1", busy);
    end
  endtask

  task automatic wait_result(input string name);
    bit   got = 1'b0;
    exp_t e;
    for (int i = 0; i < 130 * CD && !got; i++) begin
      @(negedge clk);
      if (data_valid || ack_error) got = 1'b1;
    end
    checks++;
    if (!got || exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s_result: got pulse=%0b queued=%0d want pulse with queued result", name, got, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      checks++;
      if ({ack_error, data_valid} !== (e.is_err ? 2'b10 : 2'b01)) begin
        failures++;
        $display("FAIL %s_kind: got err=%b valid=%b want err=%b", name, ack_error, data_valid, e.is_err);
      end
      checks++;
      if (temp_data !== e.data) begin
        failures++;
        $display("FAIL %s_data: got %h want %h", name, temp_data, e.data);
      end
      checks++;
      if (cyc !== e.due) begin
        failures++;
        $display("FAIL %s_latency: got cycle %0d want %0d", name, cyc, e.due);
      end
      checks++;
      if (busy !== 1'b0) begin
        failures++;
        $display("FAIL %s_busy_end: got %b want 0", name, busy);
      end
    end
  endtask

  task automatic test_reset();
    int bad_bus = 0, bad_busy = 0, bad_pulse = 0, bad_data = 0;
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      if (sda_oe !== 1'b0 || scl_oe !== 1'b0) bad_bus++;
      if (busy !== 1'b0) bad_busy++;
      if (data_valid !== 1'b0 || ack_error !== 1'b0) bad_pulse++;
      if (temp_data !== 16'h0000) bad_data++;
    end
    checks++;
    if (bad_bus !== 0) begin failures++; $display("FAIL reset_bus: got %0d driven cycles want 0", bad_bus); end
    checks++;
    if (bad_busy !== 0) begin failures++; $display("FAIL reset_busy: got %0d busy cycles want 0", bad_busy); end
    checks++;
    if (bad_pulse !== 0) begin failures++; $display("FAIL reset_pulse: got %0d pulse cycles want 0", bad_pulse); end
    checks++;
    if (bad_data !== 0) begin failures++; $display("FAIL reset_data: got %0d nonzero cycles want 0", bad_data); end
  endtask

  task automatic test_read();
    int v0 = n_valid, s0 = stops_seen;
    ack_en = 1'b1; byte0 = 8'h0C; byte1 = 8'h80;
    do_start(1'b0, 16'h0C80, 113);
    wait_result("read");
    repeat (3) @(negedge clk);
    checks++;
    if (addr_rx !== 8'h97) begin failures++; $display("FAIL read_addr: got %h want 97", addr_rx); end
    checks++;
    if (period_meas !== 4 * CD) begin failures++; $display("FAIL read_scl_period: got %0d want %0d", period_meas, 4 * CD); end
    checks++;
    if (m_ack_bit !== 1'b0) begin failures++; $display("FAIL read_master_ack: got %b want 0", m_ack_bit); end
    checks++;
    if (m_nack_bit !== 1'b1) begin failures++; $display("FAIL read_master_nack: got %b want 1", m_nack_bit); end
    checks++;
    if (stops_seen !== s0 + 1) begin failures++; $display("FAIL read_stop: got %0d want %0d", stops_seen, s0 + 1); end
    checks++;
    if (n_valid !== v0 + 1) begin failures++; $display("FAIL read_valid_cycles: got %0d want %0d", n_valid, v0 + 1); end
  endtask

  task automatic test_nack();
    int v0 = n_valid, e0 = n_err, s0 = stops_seen;
    ack_en = 1'b0;
    do_start(1'b1, 16'h0C80, 41);
    wait_result("nack");
    repeat (3) @(negedge clk);
    checks++;
    if (n_valid !== v0) begin failures++; $display("FAIL nack_valid: got %0d want %0d", n_valid, v0); end
    checks++;
    if (n_err !== e0 + 1) begin failures++; $display("FAIL nack_err_cycles: got %0d want %0d", n_err, e0 + 1); end
    checks++;
    if (stops_seen !== s0 + 1) begin failures++; $display("FAIL nack_stop: got %0d want %0d", stops_seen, s0 + 1); end
    ack_en = 1'b1;
  endtask

  task automatic test_back_to_back();
    int v0 = n_valid;
    byte0 = 8'h19; byte1 = 8'h40;
    do_start(1'b0, 16'h1940, 113);
    repeat (50 * CD - 2) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_result("b2b_first");
    repeat (3 * CD) @(negedge clk);
    checks++;
    if (n_valid !== v0 + 1) begin failures++; $display("FAIL b2b_ignored: got %0d valids want %0d", n_valid, v0 + 1); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle: got busy %b want 0", busy); end
    byte0 = 8'h12; byte1 = 8'h34;
    do_start(1'b0, 16'h1234, 113);
    wait_result("b2b_second");
    repeat (3) @(negedge clk);
    checks++;
    if (n_valid !== v0 + 2) begin failures++; $display("FAIL b2b_second_count: got %0d want %0d", n_valid, v0 + 2); end
  endtask

  task automatic test_reset_mid();
    int v0;
    byte0 = 8'hFF; byte1 = 8'hF8;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (90 * CD - 2) @(posedge clk);
    #1;
    v0 = n_valid;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (sda_oe !== 1'b0 || scl_oe !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_bus: got sda_oe=%b scl_oe=%b want 0 0", sda_oe, scl_oe);
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
    checks++;
    if (temp_data !== 16'h0000) begin failures++; $display("FAIL mid_reset_data: got %h want 0000", temp_data); end
    checks++;
    if (data_valid !== 1'b0 || ack_error !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_pulse: got valid=%b err=%b want 0 0", data_valid, ack_error);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (n_valid !== v0) begin failures++; $display("FAIL mid_reset_no_valid: got %0d want %0d", n_valid, v0); end
    do_start(1'b0, 16'hFFF8, 113);
    wait_result("after_reset");
  endtask

  task automatic test_protocol();
    repeat (5) @(negedge clk);
    checks++;
    if (proto_err !== 0) begin failures++; $display("FAIL protocol: got %0d violations want 0", proto_err); end
    checks++;
    if (stops_seen !== 5) begin failures++; $display("FAIL protocol_stops: got %0d want 5", stops_seen); end
    checks++;
    if (exp_q.size() !== 0) begin failures++; $display("FAIL protocol_pending: got %0d queued want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_nack();
    test_back_to_back();
    test_reset_mid();
    test_protocol();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
